perceptron_train_ctrl: RTL and testbench
========================================

PERCEPTRON_TRAIN_CTRL -- requirements
Module: perceptron_train_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_ENTRIES, 64, perceptron table depth; index = PC[7:2].
- GHR_SIZE, 12, weights per entry.
- WEIGHT_W, 8, signed weight width.
- THETA, 37, training threshold on |sum|.
- FIFO_DEPTH, 4, pending-update queue depth (power of 2).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high.
- up_valid, in, 1, execute offers a resolved branch.
- up_ready, out, 1, queue can accept.
- up_index, in, 6, table index of the branch.
- up_dir, in, 1, actual direction (1 = taken).
- up_sum, in, 10, signed perceptron sum used at prediction.
- up_ghr, in, GHR_SIZE, GHR snapshot used at prediction.
- rd_req, out, 1, request for the table read port.
- rd_gnt, in, 1, read port granted this cycle (fetch not using it).
- rd_addr, out, 6, table read address.
- rd_data, in, GHR_SIZE*WEIGHT_W, weights, valid the cycle after grant.
- wr_en, out, 1, table write strobe.
- wr_addr, out, 6, table write address.
- wr_data, out, GHR_SIZE*WEIGHT_W, new weights.
- init_done, out, 1, table clear sweep finished.
- train_count, out, 32, count of performed weight writes, excluding the sweep.

Function
REQ-003 FSM states: SWEEP, IDLE, READ, WAIT, WRITE.
REQ-004 SWEEP: wr_en=1, wr_data=0, wr_addr counts 0..NUM_ENTRIES-1, one entry per cycle. After entry 63 the FSM goes to IDLE and init_done=1. up_ready=0 during SWEEP.
REQ-005 The FIFO accepts one entry when up_valid&up_ready. up_ready = !full & init_done.
REQ-006 IDLE: when the FIFO is non-empty, evaluate the head. Mispredict = (up_sum>=0) != up_dir.
- Train if mispredict or |up_sum|<=THETA. Then go to READ.
- Otherwise pop the head and stay in IDLE. This costs 1 cycle per discarded update.
REQ-007 READ: rd_req=1, rd_addr=head index; hold both until rd_gnt=1, then go to WAIT.
REQ-008 WAIT: capture rd_data. Each weight w_i += (up_ghr[i]==up_dir) ? +1 : -1. Saturate to [-128,+127]. Go to WRITE.
REQ-009 WRITE: wr_en=1 for exactly one cycle with the head index and updated weights. Pop the head, increment train_count (wraps at 2^32), go to IDLE.
REQ-010 Minimum latency from accept to wr_en with an empty FIFO and immediate grant: 4 cycles (accept, IDLE, READ, WAIT; wr_en in cycle 5).
REQ-011 A push and a pop in the same cycle are both honoured; the occupancy count is unchanged. A push when full is impossible because up_ready=0.
REQ-012 Two queued updates to the same index are serialized. The second READ issues after the first WRITE, so it observes the written weights.
REQ-013 rd_req, rd_addr and wr_* are registered outputs; wr_en is never asserted in READ or WAIT.

Reset
REQ-014 reset asserted at any time, including mid-sweep or mid-update:
- state=SWEEP, FIFO emptied, sweep counter=0, train_count=0, init_done=0.
- rd_req=0, wr_en=0, wr_addr=0, wr_data=0.
- An in-flight update is discarded.
REQ-015 After reset deasserts, the sweep restarts from entry 0.

Configuration
REQ-016 Macro PERC_THRESH_TRAIN_EN.
- Defined: train on mispredict or |sum|<=THETA (REQ-006).
- Undefined: train on mispredict only. THETA is unused and correct predictions are always popped in IDLE.

Structure
REQ-017 A shared package perceptron_pkg holds:
- constants GHR_SIZE, WEIGHT_W, NUM_ENTRIES, THETA;
- the FSM state enum;
- a packed update-record typedef {index, dir, sum, ghr}.
REQ-018 The FIFO is a sub-module, perc_upd_fifo, parameterized by FIFO_DEPTH and the record width.

Verification
REQ-019 Reset release: wr_en high for 64 cycles with addr 0..63 and data 0, then init_done=1 and up_ready=1.
REQ-020 Single mispredict: index 5, dir=1, sum=-20, ghr=12'hFFF, rd_data all 0, immediate grant.
- Expected: wr_addr=5, every weight +1, train_count=1.
REQ-021 Saturation: rd_data weights all +127, dir=1, ghr=12'h000, sum=-5.
- Expected: all weights 126.
- Repeat with all -128, ghr=12'hFFF, dir=0: all weights -128 retained.
REQ-022 Threshold with the macro defined:
- sum=+37, dir=1: trains.
- sum=+38, dir=1: popped without wr_en, train_count unchanged.
- With the macro undefined, sum=+37, dir=1: not trained.
REQ-023 Back-pressure: push 4 updates while rd_gnt=0.
- Expected: up_ready=0 on the fifth offer; rd_req held with stable rd_addr.
- Grant afterwards: four writes in FIFO order.
REQ-024 Reset asserted during WAIT: no wr_en follows, the sweep restarts at address 0, train_count=0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared constants, FSM states and update record for the perceptron trainer
package perceptron_pkg;

  localparam int NUM_ENTRIES = 64;
  localparam int GHR_SIZE    = 12;
  localparam int WEIGHT_W    = 8;
  localparam int THETA       = 37;
  localparam int IDX_W       = 6;
  localparam int SUM_W       = 10;

  typedef enum logic [2:0] {SWEEP, IDLE, READ, WAIT, WRITE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]        index;
    logic                    dir;
    logic signed [SUM_W-1:0] sum;
    logic [GHR_SIZE-1:0]     ghr;
  } upd_rec_t;

  // One training step on a weight, clamped to the signed range.
  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic inc);
    logic [WEIGHT_W-1:0] max_w;
    logic [WEIGHT_W-1:0] min_w;
    max_w = {1'b0, {(WEIGHT_W-1){1'b1}}};
    min_w = {1'b1, {(WEIGHT_W-1){1'b0}}};
    if (inc) return (w == max_w) ? w : w + WEIGHT_W'(1);
    return (w == min_w) ? w : w - WEIGHT_W'(1);
  endfunction

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// rtl/perceptron_train_ctrl_if.sv - update channel and weight-table port of the perceptron trainer
interface perceptron_train_ctrl_if #(
  parameter int GHR_SIZE = 12,
  parameter int WEIGHT_W = 8
);
  logic                                up_valid;
  logic                                up_ready;
  logic [perceptron_pkg::IDX_W-1:0]    up_index;
  logic                                up_dir;
  logic signed [perceptron_pkg::SUM_W-1:0] up_sum;
  logic [GHR_SIZE-1:0]                 up_ghr;

  logic                                rd_req;
  logic                                rd_gnt;
  logic [perceptron_pkg::IDX_W-1:0]    rd_addr;
  logic [GHR_SIZE*WEIGHT_W-1:0]        rd_data;

  logic                                wr_en;
  logic [perceptron_pkg::IDX_W-1:0]    wr_addr;
  logic [GHR_SIZE*WEIGHT_W-1:0]        wr_data;

  modport master (
    output up_valid, up_index, up_dir, up_sum, up_ghr, rd_gnt, rd_data,
    input  up_ready, rd_req, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  up_valid, up_index, up_dir, up_sum, up_ghr, rd_gnt, rd_data,
    output up_ready, rd_req, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/perc_upd_fifo.sv
// rtl/perc_upd_fifo.sv - pending-update queue; caller guarantees no push when full, no pop when empty
module perc_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - perceptron weight trainer; PERC_THRESH_TRAIN_EN adds training on |sum|<=THETA
module perceptron_train_ctrl #(
  parameter int NUM_ENTRIES = perceptron_pkg::NUM_ENTRIES,
  parameter int GHR_SIZE    = perceptron_pkg::GHR_SIZE,
  parameter int WEIGHT_W    = perceptron_pkg::WEIGHT_W,
  parameter int THETA       = perceptron_pkg::THETA,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  perceptron_train_ctrl_if.slave        bus,
  output logic                          init_done,
  output logic [31:0]                   train_count
);
  import perceptron_pkg::*;

`ifdef PERC_THRESH_TRAIN_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif
  localparam int W_TOTAL = GHR_SIZE * WEIGHT_W;

  state_t                  state;
  logic [IDX_W-1:0]        sweep_cnt;
  upd_rec_t                rec_in;
  upd_rec_t                head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    mispredict;
  logic                    train;
  logic signed [SUM_W:0]   sum_ext;
  logic [SUM_W:0]          abs_sum;
  logic [W_TOTAL-1:0]      new_w;

  assign rec_in       = {bus.up_index, bus.up_dir, bus.up_sum, bus.up_ghr};
  assign bus.up_ready = init_done & ~fifo_full;
  assign push         = bus.up_valid & bus.up_ready;
  assign pop          = (state == WRITE) || (state == IDLE && !fifo_empty && !train);

  perc_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(upd_rec_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rec_in),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A non-negative sum predicts taken; extend by one bit so |-512| is representable.
  always_comb begin
    sum_ext    = {head.sum[SUM_W-1], head.sum};
    abs_sum    = sum_ext[SUM_W] ? $unsigned(-sum_ext) : $unsigned(sum_ext);
    mispredict = (~head.sum[SUM_W-1]) != head.dir;
    train      = mispredict | (THRESH_EN & (abs_sum <= (SUM_W+1)'(THETA)));
  end

  always_comb begin
    new_w = '0;
    for (int i = 0; i < GHR_SIZE; i++) begin
      new_w[i*WEIGHT_W +: WEIGHT_W] = sat_step(bus.rd_data[i*WEIGHT_W +: WEIGHT_W], head.ghr[i] == head.dir);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SWEEP;
      sweep_cnt   <= '0;
      init_done   <= 1'b0;
      train_count <= '0;
      bus.rd_req  <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      case (state)
        SWEEP: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= sweep_cnt;
          bus.wr_data <= '0;
          sweep_cnt   <= sweep_cnt + IDX_W'(1);
          if (sweep_cnt == IDX_W'(NUM_ENTRIES - 1)) state <= IDLE;
        end
        IDLE: begin
          bus.wr_en <= 1'b0;
          init_done <= 1'b1;
          if (!fifo_empty && train) begin
            state       <= READ;
            bus.rd_req  <= 1'b1;
            bus.rd_addr <= head.index;
          end
        end
        READ: begin
          if (bus.rd_gnt) begin
            bus.rd_req <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= head.index;
          bus.wr_data <= new_w;
          state       <= WRITE;
        end
        WRITE: begin
          bus.wr_en   <= 1'b0;
          train_count <= train_count + 32'd1;
          state       <= IDLE;
        end
        default: state <= SWEEP;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - scoreboard bench for perceptron_train_ctrl; honours PERC_THRESH_TRAIN_EN
module tb_perceptron_train_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic [31:0] train_count;

  perceptron_train_ctrl_if #(.GHR_SIZE(12), .WEIGHT_W(8)) bus ();

  perceptron_train_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .init_done   (init_done),
    .train_count (train_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [95:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [95:0] tbl [64];
  int          checks = 0;
  int          errors = 0;
  int          exp_tc = 0;
  bit          mon_on = 1'b0;
  bit          ok;
  int          n;
  logic        resp_g;
  logic [5:0]  resp_a;

  function automatic logic [95:0] rep(input logic [7:0] b);
    return {12{b}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Weight table model: one-cycle read latency after grant, writes land at the clock edge.
  always @(posedge clk) begin
    resp_g = bus.rd_req & bus.rd_gnt;
    resp_a = bus.rd_addr;
    if (bus.wr_en) tbl[bus.wr_addr] = bus.wr_data;
    #1;
    if (resp_g) bus.rd_data = tbl[resp_a];
  end

  always @(negedge clk) begin
    if (mon_on && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0d required no write", bus.wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 128'(bus.wr_addr), 128'(mon_e.addr));
        chk("wr_data", 128'(bus.wr_data), 128'(mon_e.data));
      end
    end
  end

  task automatic push(input logic [5:0] idx, input logic dir, input logic [9:0] sum,
                      input logic [11:0] ghr, input bit expect_wr, input logic [95:0] exp_data);
    int k = 0;
    bus.up_valid = 1'b1;
    bus.up_index = idx;
    bus.up_dir   = dir;
    bus.up_sum   = sum;
    bus.up_ghr   = ghr;
    @(negedge clk);
    while (!bus.up_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.up_ready) chk("push_timeout", 128'(bus.up_ready), 128'd1);
    else if (expect_wr) begin
      exp_q.push_back('{idx, exp_data});
      exp_tc++;
    end
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk({name, "_drain"}, 128'(exp_q.size()), 128'd0);
    chk({name, "_train_count"}, 128'(train_count), 128'(exp_tc));
    @(posedge clk);
    #1;
  endtask

  task automatic check_sweep(input string name);
    int k = 0;
    bit good = 1'b1;
    @(negedge clk);
    while (!bus.wr_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 64; i++) begin
      if (!(bus.wr_en && bus.wr_addr == 6'(i) && bus.wr_data == '0 && !init_done && !bus.up_ready))
        good = 1'b0;
      @(negedge clk);
    end
    chk({name, "_writes"}, 128'(good), 128'd1);
    chk({name, "_wr_en_off"}, 128'(bus.wr_en), 128'd0);
    chk({name, "_init_done"}, 128'(init_done), 128'd1);
    chk({name, "_up_ready"}, 128'(bus.up_ready), 128'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.up_valid = 1'b0;
    bus.up_index = '0;
    bus.up_dir   = 1'b0;
    bus.up_sum   = '0;
    bus.up_ghr   = '0;
    bus.rd_gnt   = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_wr_en", 128'(bus.wr_en), 128'd0);
    chk("rst_rd_req", 128'(bus.rd_req), 128'd0);
    chk("rst_init_done", 128'(init_done), 128'd0);
    chk("rst_up_ready", 128'(bus.up_ready), 128'd0);
    chk("rst_train_count", 128'(train_count), 128'd0);
    chk("rst_wr_addr_data", 128'({bus.wr_addr, bus.wr_data}), 128'd0);
    reset = 1'b0;
    check_sweep("sweep");
    mon_on = 1'b1;

    push(6'd5, 1'b1, -10'sd20, 12'hFFF, 1'b1, rep(8'h01));
    drain("single");

    tbl[20] = rep(8'h7F);
    tbl[21] = rep(8'h80);
    push(6'd20, 1'b1, -10'sd5, 12'h000, 1'b1, rep(8'h7E));
    push(6'd21, 1'b0, 10'sd5, 12'hFFF, 1'b1, rep(8'h80));
    push(6'd10, 1'b1, -10'sd3, 12'h00F, 1'b1, 96'hFFFFFFFF_FFFFFFFF_01010101);
    drain("saturate");

`ifdef PERC_THRESH_TRAIN_EN
    push(6'd30, 1'b1, 10'sd37, 12'hFFF, 1'b1, rep(8'h01));
    push(6'd31, 1'b0, -10'sd37, 12'h000, 1'b1, rep(8'h01));
`else
    push(6'd30, 1'b1, 10'sd37, 12'hFFF, 1'b0, '0);
    push(6'd31, 1'b0, -10'sd37, 12'h000, 1'b0, '0);
`endif
    push(6'd32, 1'b1, 10'sd38, 12'hFFF, 1'b0, '0);
    push(6'd33, 1'b0, -10'sd38, 12'h000, 1'b0, '0);
    push(6'd34, 1'b0, 10'sd0, 12'h000, 1'b1, rep(8'h01));
    drain("threshold");

    push(6'd9, 1'b1, -10'sd1, 12'hFFF, 1'b1, rep(8'h01));
    push(6'd9, 1'b1, -10'sd1, 12'hFFF, 1'b1, rep(8'h02));
    drain("same_index");

    bus.rd_gnt = 1'b0;
    for (int i = 0; i < 4; i++) push(6'(40 + i), 1'b1, -10'sd1, 12'hFFF, 1'b1, rep(8'h01));
    bus.up_valid = 1'b1;
    bus.up_index = 6'd44;
    @(negedge clk);
    chk("bp_up_ready", 128'(bus.up_ready), 128'd0);
    ok = 1'b1;
    repeat (5) begin
      if (!(bus.rd_req && bus.rd_addr == 6'd40)) ok = 1'b0;
      @(negedge clk);
    end
    bus.up_valid = 1'b0;
    chk("bp_rd_hold", 128'(ok), 128'd1);
    chk("bp_no_write", 128'(exp_q.size()), 128'd4);
    @(posedge clk);
    #1;
    bus.rd_gnt = 1'b1;
    drain("backpressure");

    push(6'd50, 1'b1, -10'sd1, 12'hFFF, 1'b0, '0);
    n = 0;
    @(negedge clk);
    while (!bus.rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_read", 128'(bus.rd_req), 128'd1);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_on = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", 128'(bus.wr_en), 128'd0);
    chk("midrst_rd_req", 128'(bus.rd_req), 128'd0);
    chk("midrst_init_done", 128'(init_done), 128'd0);
    chk("midrst_train_count", 128'(train_count), 128'd0);
    exp_tc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_sweep("resweep");
    mon_on = 1'b1;

    push(6'd5, 1'b1, -10'sd20, 12'hFFF, 1'b1, rep(8'h01));
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
